// File: rtl/systolic_mac_array.sv
// Output-stationary signed DIMxDIM systolic MAC array with IDLE/RUN/DONE run controller.
// Operands enter pre-skewed at the left/top edges; accumulators are read one row per cycle.
module systolic_mac_array #(
  parameter int DIM     = 8,
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stall,
  input  logic [DIM*BITS_AB-1:0]    a_in,
  input  logic [DIM*BITS_AB-1:0]    b_in,
  output logic                      fifo_en,
  output logic                      busy,
  output logic                      done,
  input  logic [$clog2(DIM)-1:0]    c_sel,
  output logic [DIM*BITS_C-1:0]     c_row
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int             CW       = $clog2(3*DIM);
  localparam logic [CW-1:0]  CNT_LAST = CW'(3*DIM-3);

  state_e                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic signed [BITS_AB-1:0]  a_q [DIM][DIM];
  logic signed [BITS_AB-1:0]  b_q [DIM][DIM];
  logic signed [BITS_AB-1:0]  a_l [DIM][DIM];
  logic signed [BITS_AB-1:0]  b_t [DIM][DIM];
  logic signed [BITS_C-1:0]   acc_q [DIM][DIM];
  logic signed [BITS_C-1:0]   acc_d [DIM][DIM];
  logic [DIM*BITS_C-1:0]      c_row_q, c_row_d;
  logic                       clear, active;

  always_comb begin
    clear   = (state_q == IDLE) && start;
    active  = (state_q == RUN) && !stall;
    fifo_en = active;
    busy    = (state_q == RUN);
    done    = (state_q == DONE);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Edge PEs take the external lane; interior PEs take the neighbour's pipeline register.
  for (genvar i = 0; i < DIM; i++) begin : g_row
    for (genvar j = 0; j < DIM; j++) begin : g_col
      logic signed [BITS_C-1:0] a_ext, b_ext;

      if (j == 0) begin : g_a_edge
        assign a_l[i][j] = a_in[i*BITS_AB +: BITS_AB];
      end else begin : g_a_int
        assign a_l[i][j] = a_q[i][j-1];
      end

      if (i == 0) begin : g_b_edge
        assign b_t[i][j] = b_in[j*BITS_AB +: BITS_AB];
      end else begin : g_b_int
        assign b_t[i][j] = b_q[i-1][j];
      end

      assign a_ext       = BITS_C'(a_l[i][j]);
      assign b_ext       = BITS_C'(b_t[i][j]);
      assign acc_d[i][j] = acc_q[i][j] + a_ext * b_ext;
    end
  end

  for (genvar j = 0; j < DIM; j++) begin : g_rd
    assign c_row_d[j*BITS_C +: BITS_C] = acc_q[c_sel][j];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      acc_q   <= '{default: '0};
      c_row_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c_row_q <= c_row_d;
      if (clear) begin
        a_q   <= '{default: '0};
        b_q   <= '{default: '0};
        acc_q <= '{default: '0};
      end else if (active) begin
        a_q   <= a_l;
        b_q   <= b_t;
        acc_q <= acc_d;
      end
    end
  end

  assign c_row = c_row_q;

endmodule

// File: tb/tb_systolic_mac_array.sv
// Directed bench for systolic_mac_array (DIM=8): uniform-matrix vector table plus
// identity, stall, start-ignore, back-to-back, mid-run reset and readout sequences.
module tb_systolic_mac_array;
  localparam int DIM = 8;
  localparam int BA  = 8;
  localparam int BC  = 32;

  logic                clk = 1'b0;
  logic                rst, start, stall;
  logic [DIM*BA-1:0]   a_in, b_in;
  logic                fifo_en, busy, done;
  logic [2:0]          c_sel;
  logic [DIM*BC-1:0]   c_row;

  systolic_mac_array #(.DIM(DIM), .BITS_AB(BA), .BITS_C(BC)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .a_in(a_in), .b_in(b_in), .fifo_en(fifo_en), .busy(busy), .done(done),
    .c_sel(c_sel), .c_row(c_row)
  );

  always #5 clk = ~clk;

  typedef struct {
    int av;
    int bv;
    int ce;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int A [DIM][DIM];
  int B [DIM][DIM];
  int Cexp [DIM][DIM];
  int t;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_row(input string name, input int r);
    logic [DIM*BC-1:0] req;
    for (int j = 0; j < DIM; j++) req[j*BC +: BC] = BC'(Cexp[r][j]);
    checks++;
    if (c_row !== req) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h required=%h", name, r, c_row, req);
    end
  endtask

  task automatic fill_uniform(input int av, input int bv, input int ce);
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        A[i][j] = av; B[i][j] = bv; Cexp[i][j] = ce;
      end
  endtask

  task automatic fill_identity();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        A[i][j]    = (i == j) ? 1 : 0;
        B[i][j]    = i*DIM + j;
        Cexp[i][j] = i*DIM + j;
      end
  endtask

  // Skewed edge lanes for active cycle t: row/column k arrives k+lane cycles late.
  task automatic drive_ops();
    for (int i = 0; i < DIM; i++) begin
      a_in[i*BA +: BA] = (t-i >= 0 && t-i < DIM) ? BA'(A[i][t-i]) : '0;
      b_in[i*BA +: BA] = (t-i >= 0 && t-i < DIM) ? BA'(B[t-i][i]) : '0;
    end
  endtask

  task automatic run(input int stall_at, input int stall_len, input int pulse_at,
                     input bit pulse_in_done, output int fifo_cnt, output int done_cyc,
                     output int stall_hi);
    int cyc;
    logic en;
    fifo_cnt = 0; done_cyc = -1; stall_hi = 0;
    t = 0;
    drive_ops();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 100) begin
      stall = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      start = (cyc == pulse_at);
      drive_ops();
      #1;
      en = fifo_en;
      if (stall && fifo_en) stall_hi++;
      if (fifo_en) fifo_cnt++;
      if (done) begin
        done_cyc = cyc;
        stall    = 1'b0;
        start    = pulse_in_done;
        @(posedge clk); #1;
        start = 1'b0;
        break;
      end
      @(posedge clk); #1;
      if (en) t++;
      cyc++;
    end
    stall = 1'b0;
    start = 1'b0;
  endtask

  task automatic read_rows(input string name, input bit check_prev);
    for (int r = 0; r < DIM; r++) begin
      c_sel = 3'(r);
      #1;
      if (check_prev && r > 0) chk_row({name, "_prev"}, r-1);
      @(posedge clk); #1;
      chk_row(name, r);
    end
  endtask

  vec_t vecs [6];
  int fc, dc, sh;

  initial begin
    vecs[0] = '{av: -128, bv: -128, ce: 131072};
    vecs[1] = '{av: -128, bv:  127, ce: -130048};
    vecs[2] = '{av:  127, bv:  127, ce: 129032};
    vecs[3] = '{av:    3, bv:   -5, ce: -120};
    vecs[4] = '{av:   -1, bv:    1, ce: -8};
    vecs[5] = '{av:    1, bv:    1, ce: 8};

    rst = 1'b1; start = 1'b0; stall = 1'b0; c_sel = '0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_fifo_en", fifo_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_c_row_zero", (c_row == '0), 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Identity product with readout sweep and select-to-row latency check.
    fill_identity();
    run(1000, 0, 1000, 1'b0, fc, dc, sh);
    chk("ident_fifo_cycles", fc, 22);
    chk("ident_done_cycle", dc, 23);
    chk("ident_post_done_busy", busy, 0);
    chk("ident_done_single", done, 0);
    read_rows("ident_row", 1'b1);

    for (int v = 0; v < 6; v++) begin
      fill_uniform(vecs[v].av, vecs[v].bv, vecs[v].ce);
      run(1000, 0, 1000, 1'b0, fc, dc, sh);
      chk($sformatf("vec%0d_fifo_cycles", v), fc, 22);
      chk($sformatf("vec%0d_done_cycle", v), dc, 23);
      read_rows($sformatf("vec%0d_row", v), 1'b0);
    end

    // Three-cycle stall in the middle of the run.
    fill_identity();
    run(7, 3, 1000, 1'b0, fc, dc, sh);
    chk("stall_fifo_hi_during_stall", sh, 0);
    chk("stall_fifo_cycles", fc, 22);
    chk("stall_done_cycle", dc, 26);
    read_rows("stall_row", 1'b0);

    // Start pulsed in RUN and in DONE is ignored; then back-to-back start.
    fill_identity();
    run(1000, 0, 9, 1'b1, fc, dc, sh);
    chk("ign_fifo_cycles", fc, 22);
    chk("ign_done_cycle", dc, 23);
    chk("ign_no_restart_busy", busy, 0);
    fill_uniform(-1, 1, -8);
    run(1000, 0, 1000, 1'b0, fc, dc, sh);
    chk("b2b_done_cycle", dc, 23);
    read_rows("b2b_row", 1'b0);

    // Reset while the counter is 10.
    fill_identity();
    c_sel = '0;
    t = 0;
    drive_ops();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 40 && t < 10; c++) begin
      logic en;
      drive_ops();
      #1;
      en = fifo_en;
      @(posedge clk); #1;
      if (en) t++;
    end
    chk("rst_mid_reached_cnt10", t, 10);
    chk("rst_mid_busy_before", busy, 1);
    chk("rst_mid_partial_nonzero", (c_row != '0), 1);
    rst = 1'b1;
    drive_ops();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_fifo_en", fifo_en, 0);
    fill_uniform(0, 0, 0);
    chk_row("rst_mid_c_row_now", 0);
    read_rows("rst_mid_zero_row", 1'b0);
    fill_uniform(3, -5, -120);
    run(1000, 0, 1000, 1'b0, fc, dc, sh);
    chk("rst_after_done_cycle", dc, 23);
    read_rows("rst_after_row", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_mac_array.md
# systolic_mac_array

Signed int8 DIM×DIM output-stationary systolic multiply-accumulate array with its own run controller. It consumes the skewed operand streams produced by the row (A) and column (B) delay FIFOs. It drives those FIFOs' shift enable for exactly the number of cycles one matrix product needs. Results stay in per-PE accumulators until the next start, and host logic reads them one row at a time.

## Interface
- `DIM`, default 8, array edge size; a power of two ≥ 2.
- `BITS_AB`, default 8, signed operand width.
- `BITS_C`, default 32, signed accumulator width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a product; sampled only in IDLE.
- `stall`  in  1  freeze array and counter while in RUN.
- `a_in`  in  DIM*BITS_AB  left-edge operands; lane i (bits i*BITS_AB +: BITS_AB) feeds row i.
- `b_in`  in  DIM*BITS_AB  top-edge operands; lane j feeds column j.
- `fifo_en`  out  1  shift enable to all operand FIFOs.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse when the product is complete.
- `c_sel`  in  $clog2(DIM)  accumulator row to read.
- `c_row`  out  DIM*BITS_C  registered accumulators of row `c_sel`; lane j is C[c_sel][j].

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE and `start` → RUN:
  - all accumulators and pipeline registers clear to 0 on that edge;
  - the cycle counter loads 0.
- RUN, `stall`=0. Each cycle:
  - `fifo_en`=1;
  - every PE(i,j) does acc += a_l*b_t, a full-precision signed product, sign-extended to BITS_C;
  - a_l = `a_in` lane i for j=0, otherwise a_reg[i][j-1];
  - b_t = `b_in` lane j for i=0, otherwise b_reg[i-1][j];
  - a_reg[i][j] ← a_l and b_reg[i][j] ← b_t;
  - the counter increments.
- RUN, `stall`=1: `fifo_en`=0, and accumulators, pipeline registers and counter all hold.
- RUN → DONE on the non-stalled cycle where the counter = 3*DIM-3, i.e. after 3*DIM-2 active cycles.
- DONE: `done`=1 and `fifo_en`=0 for that cycle; next state is IDLE unconditionally.
- `start` in RUN or DONE is ignored. It is not queued.
- Skew is an upstream responsibility. Row i / column k must arrive k+i cycles after the first active cycle. Lanes must carry 0 outside their valid window.
- Accumulation wraps modulo 2^BITS_C with no saturation.
- Readout: `c_row` ← acc[c_sel][*] every cycle, in any state. Reads during RUN return partial sums.

## Timing
- Reset values:
  - state IDLE;
  - `fifo_en`=0, `busy`=0, `done`=0, `c_row`=0;
  - all accumulators and pipeline registers 0;
  - counter 0.
- `rst` has priority over every other input. Reset mid-RUN aborts the product and clears all state on that edge.
- `fifo_en` and `busy` are combinational from the state and `stall`. `a_in`/`b_in` are sampled on the same edge as `fifo_en`=1, so operand sources must present valid data combinationally.
- Latency with no stalls:
  - `start` at edge 0;
  - `fifo_en` high for cycles 1..3*DIM-2;
  - `done` in cycle 3*DIM-1.
- Each stalled cycle adds one cycle to this latency.
- Final results are valid from the `done` cycle onward. `c_row` reflects `c_sel` one cycle after the select is applied.
- The earliest back-to-back `start` is the cycle after `done`.

## Test plan
- Identity: A=I and B[k][j]=k*DIM+j, correctly skewed, DIM=8.
  - C equals B.
  - `fifo_en` is high for exactly 22 cycles.
  - `done` pulses at cycle 23.
- Extremes: all A and all B = -128.
  - Every C = 131072.
  - A second run with A=-128, B=127 gives every C = -130048.
- Stall: assert `stall` for 3 cycles mid-RUN.
  - `fifo_en` is low during the stall.
  - C is identical to the unstalled run.
  - `done` arrives 3 cycles late.
- Reset mid-RUN at counter 10.
  - Next cycle: `busy`=0, all `c_row` reads 0.
  - A following `start` produces a correct product.
- Pulse `start` during RUN and during DONE.
  - No restart; the counter is undisturbed.
  - Then issue `start` in the cycle after `done`: the accumulators clear and the new product is correct.
- Readout sweep: step `c_sel` over 0..7 after `done`. Each row appears exactly one cycle after its select.
